// File: rtl/mask_issue_queue_pkg.sv
// Shared types and helpers for the slot-addressed issue queue: slot index typedef,
// one-hot to index conversion and the multi-pick lowest-set-bit selector.
package mask_issue_queue_pkg;

    localparam int unsigned IqDepth    = 8;
    localparam int unsigned IqEnqWidth = 2;
    localparam int unsigned IqDeqWidth = 2;
    localparam int unsigned IqDataW    = 32;
    localparam int unsigned IqIdxW     = $clog2(IqDepth);
    localparam int unsigned IqCntW     = $clog2(IqDepth + 1);
    // Number of picks produced by multi_pick; covers both enqueue and dequeue port counts.
    localparam int unsigned IqMaxPick  = (IqEnqWidth > IqDeqWidth) ? IqEnqWidth : IqDeqWidth;

    typedef logic [IqIdxW-1:0]                iq_idx_t;
    typedef logic [IqDepth-1:0]               iq_mask_t;
    typedef iq_mask_t [IqMaxPick-1:0]         iq_picks_t;

    // Binary index of a one-hot slot mask; all-zero mask yields index 0.
    function automatic iq_idx_t onehot_to_idx(input iq_mask_t oh);
        iq_idx_t idx;
        idx = '0;
        for (int unsigned k = 0; k < IqDepth; k++) begin
            if (oh[k]) begin
                idx = idx | iq_idx_t'(k);
            end
        end
        return idx;
    endfunction

    // picks[p] is the one-hot mask of the (p+1)-th lowest set bit of req, or zero if none.
    function automatic iq_picks_t multi_pick(input iq_mask_t req);
        iq_picks_t picks;
        iq_mask_t  rem;
        picks = '0;
        rem   = req;
        for (int unsigned p = 0; p < IqMaxPick; p++) begin
            picks[p] = rem & (~rem + iq_mask_t'(1));
            rem      = rem & ~picks[p];
        end
        return picks;
    endfunction

endpackage

// File: rtl/mask_issue_queue_if.sv
// Enqueue, wakeup, flush and dequeue bundle between dispatch, the issue queue and FU ports.
interface mask_issue_queue_if
    import mask_issue_queue_pkg::*;
#(
    parameter int unsigned Depth    = IqDepth,
    parameter int unsigned EnqWidth = IqEnqWidth,
    parameter int unsigned DeqWidth = IqDeqWidth,
    parameter int unsigned DataW    = IqDataW
);
    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic                               flush;
    logic [EnqWidth-1:0]                enq_vld;
    logic [EnqWidth-1:0]                enq_rdy;
    logic [EnqWidth-1:0][DataW-1:0]     enq_data;
    logic [EnqWidth-1:0]                enq_issuable;
    logic [Depth-1:0]                   wake_mask;
    logic [DeqWidth-1:0]                deq_vld;
    logic [DeqWidth-1:0]                deq_rdy;
    logic [DeqWidth-1:0][DataW-1:0]     deq_data;
    logic [DeqWidth-1:0][IdxW-1:0]      deq_idx;
    logic [CntW-1:0]                    count;
    logic                               full;
    logic                               empty;

    // Queue side.
    modport slave (
        input  flush, enq_vld, enq_data, enq_issuable, wake_mask, deq_rdy,
        output enq_rdy, deq_vld, deq_data, deq_idx, count, full, empty
    );

    // Dispatch / consumer side.
    modport master (
        output flush, enq_vld, enq_data, enq_issuable, wake_mask, deq_rdy,
        input  enq_rdy, deq_vld, deq_data, deq_idx, count, full, empty
    );

endinterface

// File: rtl/mask_onehot_mux.sv
// One-hot AND-OR read mux over the slot payload array; zero select gives zero data.
module mask_onehot_mux #(
    parameter int unsigned Depth = 8,
    parameter int unsigned DataW = 32
) (
    input  logic [Depth-1:0]             sel_i,
    input  logic [Depth-1:0][DataW-1:0]  data_i,
    output logic [DataW-1:0]             data_o
);

    // OR together the payloads of all selected slots (at most one).
    always_comb begin
        data_o = '0;
        for (int unsigned k = 0; k < Depth; k++) begin
            if (sel_i[k]) begin
                data_o = data_o | data_i[k];
            end
        end
    end

endmodule

// File: rtl/mask_issue_queue.sv
// Multi-port slot-addressed issue queue: allocates free slots to enqueue ports and
// hands the lowest-indexed issuable slots to dequeue ports, both by static priority.
module mask_issue_queue
    import mask_issue_queue_pkg::*;
#(
    parameter int unsigned Depth    = IqDepth,
    parameter int unsigned EnqWidth = IqEnqWidth,
    parameter int unsigned DeqWidth = IqDeqWidth,
    parameter int unsigned DataW    = IqDataW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mask_issue_queue_if.slave iq_io
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    if (Depth < EnqWidth || Depth < DeqWidth) begin : g_bad_depth
        $error("Depth must be at least max(EnqWidth, DeqWidth)");
    end
    // Pick masks come from the shared package, so the slot count and port counts must fit it.
    if (Depth != IqDepth || EnqWidth > IqMaxPick || DeqWidth > IqMaxPick) begin : g_bad_pkg
        $error("Queue geometry does not match mask_issue_queue_pkg");
    end

    logic [Depth-1:0]               vld_q, vld_d;
    logic [Depth-1:0]               iss_q, iss_d;
    logic [Depth-1:0][DataW-1:0]    data_q, data_d;
    logic [CntW-1:0]                count_q, count_d;

    iq_picks_t                      enq_picks, deq_picks;
    logic [EnqWidth-1:0][Depth-1:0] enq_sel;
    logic [DeqWidth-1:0][Depth-1:0] deq_sel;
    logic [EnqWidth-1:0]            enq_rdy, enq_fire;
    logic [DeqWidth-1:0]            deq_vld, deq_fire;
    logic [DeqWidth-1:0][IqIdxW-1:0] deq_idx;
    logic [DeqWidth-1:0][DataW-1:0] deq_data;

    // Allocation and select masks from registered state only; flush blocks every handshake.
    always_comb begin
        enq_picks = multi_pick(~vld_q);
        deq_picks = multi_pick(vld_q & iss_q);
        for (int unsigned i = 0; i < EnqWidth; i++) begin
            enq_sel[i]  = iq_io.flush ? '0 : enq_picks[i];
            enq_rdy[i]  = |enq_sel[i];
            enq_fire[i] = enq_rdy[i] & iq_io.enq_vld[i];
        end
        for (int unsigned j = 0; j < DeqWidth; j++) begin
            deq_sel[j]  = iq_io.flush ? '0 : deq_picks[j];
            deq_vld[j]  = |deq_sel[j];
            deq_fire[j] = deq_vld[j] & iq_io.deq_rdy[j];
            deq_idx[j]  = onehot_to_idx(deq_sel[j]);
        end
    end

    for (genvar j = 0; j < DeqWidth; j++) begin : g_deq_mux
        mask_onehot_mux #(
            .Depth (Depth),
            .DataW (DataW)
        ) u_mux (
            .sel_i  (deq_sel[j]),
            .data_i (data_q),
            .data_o (deq_data[j])
        );
    end

    // Next slot state: wake valid slots, retire dequeued slots, then write newly allocated slots.
    always_comb begin
        vld_d   = vld_q;
        iss_d   = iss_q | (iq_io.wake_mask & vld_q);
        data_d  = data_q;
        count_d = count_q;
        for (int unsigned j = 0; j < DeqWidth; j++) begin
            if (deq_fire[j]) begin
                vld_d   = vld_d & ~deq_sel[j];
                iss_d   = iss_d & ~deq_sel[j];
                count_d = count_d - CntW'(1);
            end
        end
        for (int unsigned i = 0; i < EnqWidth; i++) begin
            if (enq_fire[i]) begin
                vld_d   = vld_d | enq_sel[i];
                // Fresh entry's readiness comes only from the enqueue port, never from a wake.
                iss_d   = (iss_d & ~enq_sel[i]) | (iq_io.enq_issuable[i] ? enq_sel[i] : '0);
                count_d = count_d + CntW'(1);
                for (int unsigned k = 0; k < Depth; k++) begin
                    if (enq_sel[i][k]) begin
                        data_d[k] = iq_io.enq_data[i];
                    end
                end
            end
        end
        if (iq_io.flush) begin
            vld_d   = '0;
            iss_d   = '0;
            count_d = '0;
        end
    end

    // Slot control state and occupancy count, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            iss_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            iss_q   <= iss_d;
            count_q <= count_d;
        end
    end

    // Payload storage; meaningless while the slot is free, so it carries no reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign iq_io.enq_rdy  = enq_rdy;
    assign iq_io.deq_vld  = deq_vld;
    assign iq_io.deq_data = deq_data;
    assign iq_io.deq_idx  = deq_idx;
    assign iq_io.count    = count_q;
    assign iq_io.full     = (count_q == CntW'(Depth));
    assign iq_io.empty    = (count_q == '0);

`ifndef SYNTHESIS
    logic enq_clash, deq_clash;

    // Protocol hazards that the allocator and selector must never produce.
    always_comb begin
        enq_clash = 1'b0;
        deq_clash = 1'b0;
        for (int unsigned i = 0; i < EnqWidth; i++) begin
            if (enq_fire[i] && |(enq_sel[i] & vld_q)) begin
                enq_clash = 1'b1;
            end
        end
        for (int unsigned j = 0; j < DeqWidth; j++) begin
            for (int unsigned k = j + 1; k < DeqWidth; k++) begin
                if (deq_fire[j] && deq_fire[k] && |(deq_sel[j] & deq_sel[k])) begin
                    deq_clash = 1'b1;
                end
            end
        end
    end

    a_count_matches: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q == CntW'($countones(vld_q)));
    a_no_enq_clash: assert property (@(posedge clk_i) disable iff (rst_i) !enq_clash);
    a_no_deq_clash: assert property (@(posedge clk_i) disable iff (rst_i) !deq_clash);
`endif

endmodule

// File: tb/tb_mask_issue_queue.sv
// Randomized and directed bench for mask_issue_queue against a slot-list reference model.
module tb_mask_issue_queue;

    logic clk;
    logic rst;

    mask_issue_queue_if #(.Depth(8), .EnqWidth(2), .DeqWidth(2), .DataW(32)) iq ();

    mask_issue_queue #(
        .Depth    (8),
        .EnqWidth (2),
        .DeqWidth (2),
        .DataW    (32)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .iq_io (iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: which slots hold an entry, which are ready, and their payload.
    bit          m_vld [8];
    bit          m_iss [8];
    logic [31:0] m_data[8];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_vld[k] = 1'b0;
            m_iss[k] = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, check all outputs against the model, clock, update the model.
    task automatic step(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] ei, input logic [7:0] wk, input logic [1:0] dr,
                        input logic fl);
        int          fr[$];
        int          cd[$];
        int          cnt;
        logic [1:0]  e_rdy;
        logic [1:0]  e_vld;
        logic [2:0]  e_idx [2];
        logic [31:0] e_data[2];
        logic [31:0] din   [2];
        din[0] = d0;
        din[1] = d1;
        cnt    = 0;
        @(negedge clk);
        iq.enq_vld      = ev;
        iq.enq_data[0]  = d0;
        iq.enq_data[1]  = d1;
        iq.enq_issuable = ei;
        iq.wake_mask    = wk;
        iq.deq_rdy      = dr;
        iq.flush        = fl;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (!m_vld[k]) fr.push_back(k);
            else begin
                cnt++;
                if (m_iss[k]) cd.push_back(k);
            end
        end
        for (int i = 0; i < 2; i++) e_rdy[i] = !fl && (i < fr.size());
        for (int j = 0; j < 2; j++) begin
            if (!fl && j < cd.size()) begin
                e_vld[j]  = 1'b1;
                e_idx[j]  = 3'(cd[j]);
                e_data[j] = m_data[cd[j]];
            end else begin
                e_vld[j]  = 1'b0;
                e_idx[j]  = '0;
                e_data[j] = '0;
            end
        end
        check_eq("enq_rdy", 64'(iq.enq_rdy), 64'(e_rdy));
        check_eq("deq_vld", 64'(iq.deq_vld), 64'(e_vld));
        check_eq("deq_idx0", 64'(iq.deq_idx[0]), 64'(e_idx[0]));
        check_eq("deq_idx1", 64'(iq.deq_idx[1]), 64'(e_idx[1]));
        check_eq("deq_data0", 64'(iq.deq_data[0]), 64'(e_data[0]));
        check_eq("deq_data1", 64'(iq.deq_data[1]), 64'(e_data[1]));
        check_eq("count", 64'(iq.count), 64'(cnt));
        check_eq("full", 64'(iq.full), 64'(cnt == 8));
        check_eq("empty", 64'(iq.empty), 64'(cnt == 0));
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            for (int k = 0; k < 8; k++) if (m_vld[k] && wk[k]) m_iss[k] = 1'b1;
            for (int j = 0; j < 2; j++) begin
                if (e_vld[j] && dr[j]) begin
                    m_vld[cd[j]] = 1'b0;
                    m_iss[cd[j]] = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (ev[i] && e_rdy[i]) begin
                    m_vld[fr[i]]  = 1'b1;
                    m_iss[fr[i]]  = ei[i];
                    m_data[fr[i]] = din[i];
                end
            end
        end
    endtask

    task automatic idle_flush();
        step(2'b00, '0, '0, 2'b00, 8'h00, 2'b00, 1'b1);
    endtask

    // Four dual enqueues of non-issuable entries fill an empty queue.
    task automatic fill_not_ready();
        for (int n = 0; n < 4; n++) step(2'b11, $urandom, $urandom, 2'b00, 8'h00, 2'b00, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        iq.flush        = 1'b0;
        iq.enq_vld      = '0;
        iq.enq_data     = '0;
        iq.enq_issuable = '0;
        iq.wake_mask    = '0;
        iq.deq_rdy      = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_enq_rdy", 64'(iq.enq_rdy), 64'(2'b11));
        check_eq("rst_deq_vld", 64'(iq.deq_vld), 64'(0));
        check_eq("rst_count", 64'(iq.count), 64'(0));
        check_eq("rst_empty", 64'(iq.empty), 64'(1));
        check_eq("rst_full", 64'(iq.full), 64'(0));
        rst = 1'b0;

        // Dual enqueue into slots 0/1, visible one cycle later.
        step(2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'b11, 8'h00, 2'b00, 1'b0);
        #2;
        check_eq("t1_deq_vld", 64'(iq.deq_vld), 64'(2'b11));
        check_eq("t1_idx0", 64'(iq.deq_idx[0]), 64'(0));
        check_eq("t1_idx1", 64'(iq.deq_idx[1]), 64'(1));
        check_eq("t1_data0", 64'(iq.deq_data[0]), 64'(32'hAAAA_0001));
        check_eq("t1_data1", 64'(iq.deq_data[1]), 64'(32'hBBBB_0002));
        check_eq("t1_count", 64'(iq.count), 64'(2));
        idle_flush();

        // Full queue of waiting entries, then wake slots 2 and 5.
        fill_not_ready();
        #2;
        check_eq("t2_full", 64'(iq.full), 64'(1));
        check_eq("t2_enq_rdy", 64'(iq.enq_rdy), 64'(0));
        check_eq("t2_deq_vld", 64'(iq.deq_vld), 64'(0));
        step(2'b00, '0, '0, 2'b00, 8'h24, 2'b00, 1'b0);
        #2;
        check_eq("t2_idx0", 64'(iq.deq_idx[0]), 64'(2));
        check_eq("t2_idx1", 64'(iq.deq_idx[1]), 64'(5));
        idle_flush();

        // Slots 3 and 6 ready, only port 0 accepts: slot 6 moves to port 0.
        fill_not_ready();
        step(2'b00, '0, '0, 2'b00, 8'h48, 2'b00, 1'b0);
        step(2'b00, '0, '0, 2'b00, 8'h00, 2'b01, 1'b0);
        #2;
        check_eq("t3_deq_vld", 64'(iq.deq_vld), 64'(2'b01));
        check_eq("t3_idx0", 64'(iq.deq_idx[0]), 64'(6));
        check_eq("t3_count", 64'(iq.count), 64'(7));
        idle_flush();

        // Only slot 4 free; dequeue slot 0 while both ports request.
        fill_not_ready();
        step(2'b00, '0, '0, 2'b00, 8'h10, 2'b00, 1'b0);
        step(2'b00, '0, '0, 2'b00, 8'h00, 2'b01, 1'b0);
        step(2'b00, '0, '0, 2'b00, 8'h01, 2'b00, 1'b0);
        #2;
        check_eq("t4_enq_rdy", 64'(iq.enq_rdy), 64'(2'b01));
        check_eq("t4_idx0", 64'(iq.deq_idx[0]), 64'(0));
        step(2'b11, 32'h4444_4444, 32'h5555_5555, 2'b00, 8'h00, 2'b01, 1'b0);
        #2;
        check_eq("t4_enq_rdy_next", 64'(iq.enq_rdy), 64'(2'b01));
        check_eq("t4_count", 64'(iq.count), 64'(7));
        idle_flush();

        // Flush with enqueue and dequeue requests pending.
        step(2'b11, $urandom, $urandom, 2'b11, 8'h00, 2'b00, 1'b0);
        step(2'b11, $urandom, $urandom, 2'b11, 8'h00, 2'b00, 1'b0);
        step(2'b01, $urandom, $urandom, 2'b11, 8'h00, 2'b00, 1'b0);
        step(2'b11, $urandom, $urandom, 2'b11, 8'hFF, 2'b11, 1'b1);
        #2;
        check_eq("t5_empty", 64'(iq.empty), 64'(1));
        check_eq("t5_count", 64'(iq.count), 64'(0));

        // Asynchronous reset between edges with three entries held.
        step(2'b11, $urandom, $urandom, 2'b11, 8'h00, 2'b00, 1'b0);
        step(2'b01, $urandom, $urandom, 2'b01, 8'h00, 2'b00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_count", 64'(iq.count), 64'(0));
        check_eq("t6_empty", 64'(iq.empty), 64'(1));
        check_eq("t6_full", 64'(iq.full), 64'(0));
        check_eq("t6_enq_rdy", 64'(iq.enq_rdy), 64'(2'b11));
        check_eq("t6_deq_vld", 64'(iq.deq_vld), 64'(0));
        check_eq("t6_deq_idx", 64'(iq.deq_idx), 64'(0));
        check_eq("t6_deq_data0", 64'(iq.deq_data[0]), 64'(0));
        #1;
        rst = 1'b0;
        model_clear();

        // Random traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            step(2'($urandom), $urandom, $urandom, 2'($urandom),
                 8'($urandom & $urandom & $urandom), 2'($urandom),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
